// File: rtl/jt12_sh_pkg.sv
// Shared definitions for the ring-side write-injection stage.
//   wr_state_t : write FSM encoding (IDLE = 0, ARMED = 1)
//   slot_last  : index of the last slot of a ring with n slots
package jt12_sh_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } wr_state_t;

  function automatic int slot_last(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/jt12_sh_wr_if.sv
// Register-write request bus between the MMR side and the ring write stage.
//   wr_req   : single-cycle request pulse (honoured only while wr_busy = 0)
//   wr_slot  : target slot index
//   wr_data  : value to place in that slot
//   wr_busy  : a write is pending
//   wr_done  : one-cycle pulse, write committed
//   wr_err   : one-cycle pulse, request rejected (slot out of range)
interface jt12_sh_wr_if #(
  parameter int width = 5,
  parameter int slotw = 5
);
  logic             wr_req;
  logic [slotw-1:0] wr_slot;
  logic [width-1:0] wr_data;
  logic             wr_busy;
  logic             wr_done;
  logic             wr_err;

  modport master (
    output wr_req, wr_slot, wr_data,
    input  wr_busy, wr_done, wr_err
  );

  modport slave (
    input  wr_req, wr_slot, wr_data,
    output wr_busy, wr_done, wr_err
  );
endinterface

// File: rtl/jt12_slot_cnt.sv
// Slot tracker for a circulating per-slot shift register.
//   clk, rst : clock and synchronous active-high reset
//   clk_en   : ring advance enable
//   zero     : with clk_en, slot 0 is entering the ring this advance
//   cur      : index of the slot entering the ring this cycle
module jt12_slot_cnt
  import jt12_sh_pkg::*;
#(
  parameter int stages = 24,
  parameter int slotw  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             zero,
  output logic [slotw-1:0] cur
);

  localparam logic [slotw-1:0] SLOT_LAST = slotw'(slot_last(stages));

  logic [slotw-1:0] cnt;

  // zero only means something on an advance; on idle cycles it is ignored
  always_comb cur = (zero && clk_en) ? '0 : cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clk_en) begin
      cnt <= (cur == SLOT_LAST) ? '0 : cur + 1'b1;
    end
  end

endmodule

// File: rtl/jt12_sh_wr.sv
// Write-injection stage in front of a width x stages circulating ring.
// Recirculates drop into din; a pending register write replaces the value
// of its target slot for exactly one advance, then pulses wr_done.
//   clk, rst : clock and synchronous active-high reset (din forced to rstval)
//   clk_en   : ring advance enable shared with the ring
//   zero     : slot-0 sync marker (valid with clk_en)
//   drop     : ring output, value of the slot now entering
//   din      : ring input
//   slot     : index of the slot entering this cycle
//   bus      : write request bus (slave side)
module jt12_sh_wr
  import jt12_sh_pkg::*;
#(
  parameter int   width  = 5,
  parameter int   stages = 24,
  parameter int   slotw  = 5,
  parameter logic rstval = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             zero,
  input  logic [width-1:0] drop,
  output logic [width-1:0] din,
  output logic [slotw-1:0] slot,
  jt12_sh_wr_if.slave      bus
);

  wr_state_t        state, state_nx;
  logic [slotw-1:0] cur;
  logic [slotw-1:0] tgt_p0;
  logic [width-1:0] dat_p0;
  logic             slot_ok;
  logic             accept;
  logic             commit;
  logic             done_nx, err_nx;
  logic             done_p1, err_p1;

  jt12_slot_cnt #(
    .stages (stages),
    .slotw  (slotw)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .zero   (zero),
    .cur    (cur)
  );

  assign slot    = cur;
  assign slot_ok = int'(bus.wr_slot) < stages;

  // Commit is only evaluated in ARMED, so a request can never land in its
  // own cycle; a slot that is passing right now waits a full revolution.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    commit   = 1'b0;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.wr_req) begin
          if (slot_ok) begin
            accept   = 1'b1;
            state_nx = ARMED;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      ARMED: begin
        if (clk_en && cur == tgt_p0) begin
          commit   = 1'b1;
          done_nx  = 1'b1;
          state_nx = IDLE;
        end
      end
    endcase
  end

  // p0: request capture
  always_ff @(posedge clk) begin
    if (accept) begin
      tgt_p0 <= bus.wr_slot;
      dat_p0 <= bus.wr_data;
    end
  end

  // p1: FSM state and status pulses; reset drops any pending write silently
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      done_p1 <= 1'b0;
      err_p1  <= 1'b0;
    end else begin
      state   <= state_nx;
      done_p1 <= done_nx;
      err_p1  <= err_nx;
    end
  end

  always_comb begin
    if (rst) begin
      din = {width{rstval}};
    end else if (commit) begin
      din = dat_p0;
    end else begin
      din = drop;
    end
  end

  assign bus.wr_busy = (state == ARMED);
  assign bus.wr_done = done_p1;
  assign bus.wr_err  = err_p1;

endmodule

// File: tb/tb_jt12_sh_wr.sv
module tb_jt12_sh_wr;

  localparam int W      = 5;
  localparam int STAGES = 24;
  localparam int SW     = 5;

  logic          clk = 1'b0;
  logic          rst, clk_en, zero;
  logic [W-1:0]  drop, din;
  logic [SW-1:0] slot;

  jt12_sh_wr_if #(.width(W), .slotw(SW)) bus ();

  jt12_sh_wr #(
    .width(W), .stages(STAGES), .slotw(SW), .rstval(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .zero(zero),
    .drop(drop), .din(din), .slot(slot), .bus(bus)
  );

  always #5 clk = ~clk;

  // the ring the block feeds: din in, drop out after STAGES advances
  logic [W-1:0] ring [STAGES];
  always @(posedge clk) begin
    if (clk_en) begin
      ring[0] <= din;
      for (int i = 1; i < STAGES; i++) ring[i] <= ring[i-1];
    end
  end
  assign drop = ring[STAGES-1];

  int checks = 0;
  int errors = 0;

  // reference model: slot position, per-slot contents, pending write
  int           mcnt = 0;
  bit           pend = 0;
  int           ps = 0;
  logic [W-1:0] pd = '0;
  bit           done_q = 0, err_q = 0;
  logic [W-1:0] mem [STAGES];
  bit           mem_valid = 0;
  int           flush_cnt = 0;

  // inputs of the current cycle and expectations derived from the model
  bit            c_rst, c_ce, c_z, c_req;
  logic [SW-1:0] c_ws;
  logic [W-1:0]  c_wd;
  logic [SW-1:0] e_slot;
  logic [W-1:0]  e_din, e_drop;
  bit            e_commit, e_busy, e_done, e_err, drop_chk;

  task automatic apply(input bit r, input bit ce, input bit z, input bit rq,
                       input logic [SW-1:0] ws, input logic [W-1:0] wd);
    @(negedge clk);
    rst = r; clk_en = ce; zero = z;
    bus.wr_req = rq; bus.wr_slot = ws; bus.wr_data = wd;
    c_rst = r; c_ce = ce; c_z = z; c_req = rq; c_ws = ws; c_wd = wd;
    #2;
    e_slot   = (z && ce) ? '0 : SW'(mcnt);
    e_commit = !r && pend && ce && (int'(e_slot) == ps);
    e_din    = r ? {W{1'b1}} : (e_commit ? pd : drop);
    e_busy   = pend;
    e_done   = done_q;
    e_err    = err_q;
    drop_chk = !r && ce && mem_valid;
    e_drop   = mem[e_slot];
  endtask

  task automatic advance();
    @(posedge clk);
    if (c_rst) begin
      mcnt = 0; pend = 0; done_q = 0; err_q = 0;
      if (c_ce) flush_cnt++;
      if (flush_cnt >= STAGES) begin
        for (int i = 0; i < STAGES; i++) mem[i] = {W{1'b1}};
        mem_valid = 1;
      end else begin
        mem_valid = 0;
      end
    end else begin
      flush_cnt = 0;
      done_q = e_commit;
      err_q  = !pend && c_req && (int'(c_ws) >= STAGES);
      if (e_commit) pend = 0;
      else if (!pend && c_req && int'(c_ws) < STAGES) begin
        pend = 1; ps = int'(c_ws); pd = c_wd;
      end
      if (c_ce) begin
        if (c_z && mcnt != 0) mem_valid = 0;
        mem[e_slot] = e_din;
        mcnt = (int'(e_slot) == STAGES - 1) ? 0 : int'(e_slot) + 1;
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 30; i++) begin
      apply(1, 1, 0, 0, '0, '0);
      checks++;
      if (din !== 5'h1F) begin errors++; $display("FAIL reset_din cyc %0d got %h want 1f", i, din); end
      if (i > 0) begin
        checks++;
        if ({bus.wr_busy, bus.wr_done, bus.wr_err} !== 3'b000) begin
          errors++; $display("FAIL reset_status cyc %0d got %b want 000", i, {bus.wr_busy, bus.wr_done, bus.wr_err});
        end
      end
      advance();
    end
    for (int i = 0; i < 2 * STAGES; i++) begin
      apply(0, 1, 0, 0, '0, '0);
      checks++;
      if (slot !== SW'(i % STAGES)) begin errors++; $display("FAIL reset_slot cyc %0d got %0d want %0d", i, slot, i % STAGES); end
      checks++;
      if (din !== 5'h1F || drop !== 5'h1F) begin errors++; $display("FAIL reset_recirc cyc %0d din %h drop %h want 1f", i, din, drop); end
      checks++;
      if (bus.wr_busy !== 1'b0) begin errors++; $display("FAIL reset_busy cyc %0d got %b want 0", i, bus.wr_busy); end
      advance();
    end
  endtask

  task automatic test_basic_write();
    apply(0, 1, 1, 0, '0, '0);
    checks++;
    if (slot !== 5'd0) begin errors++; $display("FAIL basic_zero slot got %0d want 0", slot); end
    advance();
    apply(0, 1, 0, 0, '0, '0); advance();
    apply(0, 1, 0, 1, 5'd5, 5'h0A);
    checks++;
    if (slot !== 5'd2 || din !== drop) begin errors++; $display("FAIL basic_req slot %0d din %h want slot 2 din %h", slot, din, drop); end
    advance();
    for (int k = 1; k <= 3; k++) begin
      apply(0, 1, 0, 0, '0, '0);
      checks++;
      if (bus.wr_busy !== 1'b1) begin errors++; $display("FAIL basic_busy k %0d got %b want 1", k, bus.wr_busy); end
      checks++;
      if (k == 3 && (slot !== 5'd5 || din !== 5'h0A)) begin
        errors++; $display("FAIL basic_commit slot %0d din %h want slot 5 din 0a", slot, din);
      end else if (k != 3 && din !== drop) begin
        errors++; $display("FAIL basic_early k %0d din %h want %h", k, din, drop);
      end
      advance();
    end
    apply(0, 1, 0, 0, '0, '0);
    checks++;
    if (bus.wr_done !== 1'b1 || bus.wr_busy !== 1'b0) begin
      errors++; $display("FAIL basic_done done %b busy %b want 1 0", bus.wr_done, bus.wr_busy);
    end
    advance();
    for (int i = 0; i < 30; i++) begin
      apply(0, 1, 0, 0, '0, '0);
      checks++;
      if (bus.wr_done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse cyc %0d got %b want 0", i, bus.wr_done); end
      checks++;
      if (drop !== (slot == 5'd5 ? 5'h0A : 5'h1F)) begin
        errors++; $display("FAIL basic_readback slot %0d got %h want %h", slot, drop, (slot == 5'd5 ? 5'h0A : 5'h1F));
      end
      advance();
    end
  endtask

  task automatic test_missed_slot();
    for (int i = 0; i < 60 && mcnt != 7; i++) begin apply(0, 1, 0, 0, '0, '0); advance(); end
    checks++;
    if (mcnt != 7) begin errors++; $display("FAIL missed_align got %0d want 7", mcnt); end
    apply(0, 1, 0, 1, 5'd7, 5'h15);
    checks++;
    if (slot !== 5'd7 || din !== drop) begin errors++; $display("FAIL missed_no_commit slot %0d din %h want 7 %h", slot, din, drop); end
    advance();
    for (int k = 1; k <= STAGES; k++) begin
      apply(0, 1, 0, 0, '0, '0);
      checks++;
      if (bus.wr_busy !== 1'b1) begin errors++; $display("FAIL missed_busy k %0d got %b want 1", k, bus.wr_busy); end
      checks++;
      if (din !== (k == STAGES ? 5'h15 : drop)) begin
        errors++; $display("FAIL missed_din k %0d got %h want %h", k, din, (k == STAGES ? 5'h15 : drop));
      end
      advance();
    end
    apply(0, 1, 0, 0, '0, '0);
    checks++;
    if (bus.wr_done !== 1'b1 || bus.wr_busy !== 1'b0) begin
      errors++; $display("FAIL missed_done done %b busy %b want 1 0", bus.wr_done, bus.wr_busy);
    end
    advance();
  endtask

  task automatic test_invalid_slot();
    for (int j = 0; j < 8; j++) begin
      apply(0, 1, 0, 1, SW'(STAGES + j), W'($urandom));
      checks++;
      if (din !== drop || bus.wr_busy !== 1'b0) begin
        errors++; $display("FAIL invalid_req slot %0d din %h busy %b want %h 0", STAGES + j, din, bus.wr_busy, drop);
      end
      advance();
      apply(0, 1, 0, 0, '0, '0);
      checks++;
      if ({bus.wr_err, bus.wr_done, bus.wr_busy} !== 3'b100) begin
        errors++; $display("FAIL invalid_err slot %0d got %b want 100", STAGES + j, {bus.wr_err, bus.wr_done, bus.wr_busy});
      end
      checks++;
      if (din !== drop) begin errors++; $display("FAIL invalid_din got %h want %h", din, drop); end
      advance();
      apply(0, 1, 0, 0, '0, '0);
      checks++;
      if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL invalid_pulse got %b want 0", bus.wr_err); end
      advance();
    end
  endtask

  task automatic test_random();
    bit ce, z, rq;
    for (int i = 0; i < 800; i++) begin
      ce = ($urandom_range(0, 3) != 0);
      z  = ce && (mcnt == 0) && ($urandom_range(0, 1) == 1);
      rq = ($urandom_range(0, 4) == 0);
      apply(0, ce, z, rq, SW'($urandom_range(0, 31)), W'($urandom));
      checks++;
      if (slot !== e_slot) begin errors++; $display("FAIL rnd_slot cyc %0d got %0d want %0d", i, slot, e_slot); end
      checks++;
      if (din !== e_din) begin errors++; $display("FAIL rnd_din cyc %0d got %h want %h", i, din, e_din); end
      checks++;
      if ({bus.wr_busy, bus.wr_done, bus.wr_err} !== {e_busy, e_done, e_err}) begin
        errors++; $display("FAIL rnd_status cyc %0d got %b want %b", i, {bus.wr_busy, bus.wr_done, bus.wr_err}, {e_busy, e_done, e_err});
      end
      if (drop_chk) begin
        checks++;
        if (drop !== e_drop) begin errors++; $display("FAIL rnd_ring cyc %0d slot %0d got %h want %h", i, e_slot, drop, e_drop); end
      end
      advance();
    end
  endtask

  task automatic test_gated_resync();
    int cyc = 0;
    bit issued = 0;
    bit ce, rq;
    for (int i = 0; i < 40 && pend; i++) begin apply(0, 1, 0, 0, '0, '0); advance(); end
    for (int i = 0; i < 400 && mcnt != 10; i++) begin
      ce = (cyc % 6 == 5);
      rq = !issued && !ce && !pend && (mcnt == 8);
      apply(0, ce, 0, rq, 5'd1, 5'h0C);
      if (rq) issued = 1;
      checks++;
      if (slot !== e_slot || din !== e_din) begin
        errors++; $display("FAIL gated_run slot %0d din %h want %0d %h", slot, din, e_slot, e_din);
      end
      advance(); cyc++;
    end
    checks++;
    if (!issued || mcnt != 10) begin errors++; $display("FAIL gated_setup issued %0d cnt %0d want 1 10", issued, mcnt); end
    for (int i = 0; i < 6; i++) begin
      ce = (cyc % 6 == 5);
      apply(0, ce, ce, 0, '0, '0);
      checks++;
      if (ce && (slot !== 5'd0 || din !== drop || bus.wr_busy !== 1'b1)) begin
        errors++; $display("FAIL gated_zero slot %0d din %h busy %b want 0 %h 1", slot, din, bus.wr_busy, drop);
      end else if (!ce && slot !== 5'd10) begin
        errors++; $display("FAIL gated_hold slot %0d want 10", slot);
      end
      advance(); cyc++;
      if (ce) break;
    end
    for (int i = 0; i < 6; i++) begin
      ce = (cyc % 6 == 5);
      apply(0, ce, 0, 0, '0, '0);
      checks++;
      if (slot !== 5'd1 || bus.wr_busy !== 1'b1) begin
        errors++; $display("FAIL gated_wait slot %0d busy %b want 1 1", slot, bus.wr_busy);
      end
      checks++;
      if (din !== (ce ? 5'h0C : drop)) begin
        errors++; $display("FAIL gated_commit ce %0d din %h want %h", ce, din, (ce ? 5'h0C : drop));
      end
      advance(); cyc++;
    end
    apply(0, 0, 0, 0, '0, '0);
    checks++;
    if (bus.wr_done !== 1'b1 || bus.wr_busy !== 1'b0) begin
      errors++; $display("FAIL gated_done done %b busy %b want 1 0", bus.wr_done, bus.wr_busy);
    end
    advance();
  endtask

  task automatic test_reset_mid_write();
    for (int i = 0; i < 40 && (pend || mcnt != 0); i++) begin apply(0, 1, 0, 0, '0, '0); advance(); end
    apply(0, 1, 0, 1, 5'd20, 5'h03); advance();
    for (int i = 0; i < 3; i++) begin apply(0, 1, 0, 0, '0, '0); advance(); end
    checks++;
    if (bus.wr_busy !== 1'b1) begin errors++; $display("FAIL midrst_pending got %b want 1", bus.wr_busy); end
    for (int i = 0; i < 30; i++) begin
      apply(1, 1, 0, 0, '0, '0);
      checks++;
      if (bus.wr_done !== 1'b0 || bus.wr_err !== 1'b0 || din !== 5'h1F) begin
        errors++; $display("FAIL midrst_in_reset done %b err %b din %h want 0 0 1f", bus.wr_done, bus.wr_err, din);
      end
      advance();
    end
    for (int i = 0; i < 2 * STAGES; i++) begin
      apply(0, 1, 0, 0, '0, '0);
      checks++;
      if (i == 0 && slot !== 5'd0) begin errors++; $display("FAIL midrst_cnt got %0d want 0", slot); end
      checks++;
      if ({bus.wr_busy, bus.wr_done, bus.wr_err} !== 3'b000) begin
        errors++; $display("FAIL midrst_status cyc %0d got %b want 000", i, {bus.wr_busy, bus.wr_done, bus.wr_err});
      end
      checks++;
      if (drop !== 5'h1F || din !== 5'h1F) begin
        errors++; $display("FAIL midrst_ring slot %0d drop %h din %h want 1f", slot, drop, din);
      end
      advance();
    end
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b0; zero = 1'b0;
    bus.wr_req = 1'b0; bus.wr_slot = '0; bus.wr_data = '0;
    test_reset();
    test_basic_write();
    test_missed_slot();
    test_invalid_slot();
    test_random();
    test_gated_resync();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
